apb_reg_arbiter: RTL and testbench

- Shares one APB slave port (the generated 16-bit-address / 32-bit-data register block) between NUM_REQ requesters, for example the CPU bridge and the debug/test port.
- Requesters use a simple valid/ready command channel and receive a one-cycle response pulse.
- The block arbitrates round-robin and sequences the APB SETUP and ACCESS phases.
- It supports slave wait states and enforces a bounded-wait timeout.

---
 rtl/apb_reg_arb_pkg.sv | 37 +++
 rtl/apb_reg_arbiter_rr_arbiter.sv | 29 ++
 rtl/apb_reg_arbiter.sv | 134 +++++++++++++
 tb/tb_apb_reg_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_reg_arb_pkg.sv
// rtl/apb_reg_arb_pkg.sv - shared types, defaults and rotated-priority grant helper
package apb_reg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 16;
  localparam int MAX_REQ         = 8;

  // First set bit of req searching upward from ptr+1, wrapping at n requesters.
  function automatic logic [MAX_REQ-1:0] rr_grant(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         ptr,
    input logic [3:0]         n
  );
    logic [MAX_REQ-1:0] gnt;
    logic [3:0]         idx;
    logic               found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= n) idx = idx - n;
      if ((4'(k) <= n) && !found && req[idx[2:0]]) begin
        gnt[idx[2:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/apb_reg_arbiter_rr_arbiter.sv
// rtl/apb_reg_arbiter_rr_arbiter.sv - combinational round-robin grant with encoded index
module rr_arbiter
  import apb_reg_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] gnt_ext;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
    gnt_ext              = enable ? rr_grant(req_ext, 3'(rr_ptr), 4'(NUM_REQ)) : '0;
    grant                = gnt_ext[NUM_REQ-1:0];
    grant_idx            = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (gnt_ext[i]) grant_idx = PTR_W'(i);
    end
  end

endmodule

// File: rtl/apb_reg_arbiter.sv
// rtl/apb_reg_arbiter.sv - shares one APB slave port between NUM_REQ requesters
module apb_reg_arbiter
  import apb_reg_arb_pkg::*;
#(
  parameter  int NUM_REQ     = 2,
  parameter  int ADDR_W      = DEF_ADDR_W,
  parameter  int DATA_W      = DEF_DATA_W,
  parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int PTR_W       = $clog2(NUM_REQ),
  localparam int CNT_W       = $clog2(TIMEOUT_CYC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  output logic                      pwrite,
  output logic                      psel,
  output logic                      penable,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  apb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                pwrite_q, pwrite_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [NUM_REQ-1:0]  gnt;
  logic [PTR_W-1:0]    gnt_idx;
  logic                arb_en;

  // Grant is masked during reset so every output reads zero while rst is high.
  assign arb_en = (state_q == ST_IDLE) && !rst;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .enable    (arb_en),
    .grant     (gnt),
    .grant_idx (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          paddr_d  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
          pwdata_d = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
          pwrite_d = req_write[gnt_idx];
          rr_ptr_d = gnt_idx;
          cnt_d    = '0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          rsp_valid_d = NUM_REQ'(1) << rr_ptr_q;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          state_d     = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rsp_valid_d = NUM_REQ'(1) << rr_ptr_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= PTR_W'(NUM_REQ - 1);
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwrite    = pwrite_q;
  assign psel      = (state_q != ST_IDLE);
  assign penable   = (state_q == ST_ACCESS);

endmodule

// File: tb/tb_apb_reg_arbiter.sv
// tb/tb_apb_reg_arbiter.sv - randomized bench with transaction-level reference model
module tb_apb_reg_arbiter;

  localparam int NR = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_write, req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, pwdata, prdata;
  logic            rsp_err, pwrite, psel, penable, pready, pslverr;
  logic [AW-1:0]   paddr;

  apb_reg_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  // requester command slots
  bit            cmd_v [NR];
  bit            cmd_w [NR];
  logic [AW-1:0] cmd_a [NR];
  logic [DW-1:0] cmd_d [NR];
  bit            outst [NR];
  bit            auto_re [NR];
  bit            rand_en   = 1'b0;
  int            wait_mode = 0;

  // reference model state
  bit            busy = 1'b0;
  int            age, wcnt, who;
  bit            cw;
  logic [AW-1:0] ca;
  logic [DW-1:0] cd;
  int            ptr = NR - 1;
  bit            rsp_pend = 1'b0;
  int            rsp_who;
  logic [DW-1:0] h_rdata;
  bit            h_err;
  logic [DW-1:0] reg4 = 32'h0, regc = 32'h0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic bit mapped(input logic [AW-1:0] a);
    return (a == 16'h0000) || (a == 16'h0004) || (a == 16'h000C);
  endfunction

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    if (a == 16'h0000) return 32'hA1C0_0001;
    if (a == 16'h0004) return reg4;
    if (a == 16'h000C) return regc;
    return 32'hBAD0_0000 | {16'h0, a};
  endfunction

  function automatic logic [AW-1:0] pick_addr(input int s);
    case (s)
      0: return 16'h0000;
      1: return 16'h0004;
      2: return 16'h0008;
      3: return 16'h000C;
      default: return 16'h0010;
    endcase
  endfunction

  function automatic int pick_wait();
    int r;
    if (wait_mode == 0) return 0;
    if (wait_mode == 2) return 1000;
    r = int'($urandom % 16);
    if (r < 12) return r % 4;
    if (r == 12) return TO - 2;
    if (r == 13) return TO - 1;
    if (r == 14) return TO;
    return TO + 4;
  endfunction

  // Drives requesters and slave, and compares every DUT output against the model each cycle.
  always @(negedge clk) begin
    logic [NR-1:0] want_rdy;
    int            w, j, idx;
    bit            done, tmo;
    cyc++;
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_pwdata", pwdata, 0);
      chk("rst_pwrite", pwrite, 0);
      busy = 1'b0; rsp_pend = 1'b0; ptr = NR - 1;
      h_rdata = '0; h_err = 1'b0; ca = '0; cd = '0; cw = 1'b0;
      for (int i = 0; i < NR; i++) begin cmd_v[i] = 1'b0; outst[i] = 1'b0; end
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      pready = 1'b0; pslverr = 1'b0; prdata = '0;
    end else begin
      chk("psel", psel, busy);
      chk("penable", penable, busy && age >= 2);
      chk("paddr", paddr, ca);
      chk("pwrite", pwrite, cw);
      chk("pwdata", pwdata, cd);
      chk("rsp_valid", rsp_valid, rsp_pend ? (NR'(1) << rsp_who) : NR'(0));
      chk("rsp_rdata", rsp_rdata, h_rdata);
      chk("rsp_err", rsp_err, h_err);
      if (rsp_pend) begin
        outst[rsp_who] = 1'b0;
        if (auto_re[rsp_who]) cmd_v[rsp_who] = 1'b1;
      end
      rsp_pend = 1'b0;

      done = 1'b0; tmo = 1'b0;
      pready = 1'b0; pslverr = 1'($urandom % 2); prdata = $urandom;
      if (busy && age >= 2) begin
        j = age - 2;
        if (j >= wcnt) begin
          pready  = 1'b1;
          pslverr = !mapped(ca);
          prdata  = cw ? $urandom : rd_val(ca);
          done    = 1'b1;
        end else if (j == TO - 1) begin
          done = 1'b1; tmo = 1'b1;
        end
      end

      if (rand_en) begin
        for (int i = 0; i < NR; i++) begin
          if (!cmd_v[i] && !outst[i] && ($urandom % 4 == 0)) begin
            cmd_v[i] = 1'b1; cmd_w[i] = 1'($urandom % 2);
            cmd_a[i] = pick_addr(int'($urandom % 5)); cmd_d[i] = $urandom;
          end else if (cmd_v[i] && ($urandom % 16 == 0)) begin
            cmd_v[i] = 1'b0;
          end
        end
      end
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = cmd_v[i]; req_write[i] = cmd_w[i];
        req_addr[i*AW +: AW] = cmd_a[i]; req_wdata[i*DW +: DW] = cmd_d[i];
      end
      #1;
      w = -1;
      if (!busy) begin
        for (int k = 1; k <= NR; k++) begin
          idx = (ptr + k) % NR;
          if (w < 0 && cmd_v[idx]) w = idx;
        end
      end
      want_rdy = (w >= 0) ? (NR'(1) << w) : NR'(0);
      chk("req_ready", req_ready, want_rdy);

      if (w >= 0) begin
        busy = 1'b1; age = 1; who = w; ptr = w;
        cw = cmd_w[w]; ca = cmd_a[w]; cd = cmd_d[w];
        cmd_v[w] = 1'b0; outst[w] = 1'b1; wcnt = pick_wait();
      end else if (busy) begin
        if (done) begin
          busy = 1'b0; rsp_pend = 1'b1; rsp_who = who;
          h_rdata = (tmo || cw) ? '0 : prdata;
          h_err   = tmo ? 1'b1 : pslverr;
          if (!tmo && cw) begin
            if (ca == 16'h0004) reg4 = cd;
            else if (ca == 16'h000C) regc = cd;
          end
        end else begin
          age++;
        end
      end
    end
  end

  task automatic do_xfer(input int r, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output logic [DW-1:0] rd, output bit er, output int lat, output int acc);
    int t0;
    bit got;
    t0 = 0; got = 1'b0; acc = 0; rd = '0; er = 1'b0; lat = -1;
    @(negedge clk); #2;
    cmd_w[r] = wr; cmd_a[r] = a; cmd_d[r] = d; cmd_v[r] = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk); #2;
      if (req_ready[r]) t0 = cyc;
      if (penable) acc++;
      if (rsp_valid[r]) begin
        rd = rsp_rdata; er = rsp_err; lat = cyc - t0; got = 1'b1;
      end
    end
    chk("xfer_completed", got, 1);
  endtask

  task automatic drain();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 400 && !idle; k++) begin
      @(negedge clk); #2;
      idle = !busy && !rsp_pend;
      for (int i = 0; i < NR; i++) if (cmd_v[i] || outst[i]) idle = 1'b0;
    end
    chk("drain_idle", idle, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] rd;
    bit            er, seen;
    int            lat, acc, n;
    logic [NR-1:0] g [4];
    int            gc [4];

    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    for (int i = 0; i < NR; i++) begin
      cmd_v[i] = 1'b0; cmd_w[i] = 1'b0; cmd_a[i] = '0; cmd_d[i] = '0;
      outst[i] = 1'b0; auto_re[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    do_xfer(0, 1'b0, 16'h0000, $urandom, rd, er, lat, acc);
    chk("id_rdata", rd, 32'hA1C0_0001);
    chk("id_err", er, 0);
    chk("id_latency", lat, 3);

    do_xfer(1, 1'b1, 16'h0004, 32'h1234_5678, rd, er, lat, acc);
    chk("wr4_err", er, 0);
    chk("wr4_rdata", rd, 0);
    do_xfer(1, 1'b0, 16'h0004, $urandom, rd, er, lat, acc);
    chk("rd4_rdata", rd, 32'h1234_5678);

    do_xfer(0, 1'b0, 16'h0008, $urandom, rd, er, lat, acc);
    chk("unmapped_err", er, 1);
    do_xfer(0, 1'b0, 16'h0004, $urandom, rd, er, lat, acc);
    chk("after_err_err", er, 0);

    wait_mode = 2;
    do_xfer(2, 1'b0, 16'h0000, $urandom, rd, er, lat, acc);
    chk("timeout_err", er, 1);
    chk("timeout_rdata", rd, 0);
    chk("timeout_access_cycles", acc, TO);
    chk("timeout_latency", lat, TO + 2);

    @(negedge clk); #2;
    cmd_w[0] = 1'b0; cmd_a[0] = 16'h0004; cmd_d[0] = $urandom; cmd_v[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk); #2;
      seen = penable;
    end
    chk("abort_reached_access", seen, 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_psel", psel, 0);
    chk("abort_penable", penable, 0);
    @(negedge clk);
    @(posedge clk); #1;
    wait_mode = 0;
    rst = 1'b0;

    @(negedge clk); #2;
    auto_re[0] = 1'b1; auto_re[1] = 1'b1;
    cmd_w[0] = 1'b0; cmd_a[0] = 16'h0000; cmd_d[0] = $urandom; cmd_v[0] = 1'b1;
    cmd_w[1] = 1'b0; cmd_a[1] = 16'h0004; cmd_d[1] = $urandom; cmd_v[1] = 1'b1;
    n = 0;
    for (int k = 0; k < 100 && n < 4; k++) begin
      @(negedge clk); #2;
      if (req_ready != '0) begin g[n] = req_ready; gc[n] = cyc; n++; end
    end
    chk("rr_grant_count", n, 4);
    chk("rr_grant0", g[0], 3'b001);
    chk("rr_grant1", g[1], 3'b010);
    chk("rr_grant2", g[2], 3'b001);
    chk("rr_grant3", g[3], 3'b010);
    chk("rr_spacing01", gc[1] - gc[0], 3);
    chk("rr_spacing12", gc[2] - gc[1], 3);
    auto_re[0] = 1'b0; auto_re[1] = 1'b0;
    drain();

    wait_mode = 1;
    rand_en   = 1'b1;
    repeat (3000) @(negedge clk);
    #2 rand_en = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
